// File: rtl/formatter_demux_pkg.sv
// rtl/formatter_demux_pkg.sv - shared constants and types for the 1-to-8 formatter deserializer
// Purpose: word/frame geometry and FSM state encoding used by formatter_demux and fmt_demux_outreg.
// Contents: WIDTH, NSLOT, SLOT_W, CNT_W, state_t, frame_t (lane 0 = slot 0).
package formatter_demux_pkg;

  localparam int WIDTH  = 21;
  localparam int NSLOT  = 8;
  localparam int SLOT_W = 3;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  typedef logic [NSLOT-1:0][WIDTH-1:0] frame_t;

endpackage

// File: rtl/fmt_demux_outreg.sv
// rtl/fmt_demux_outreg.sv - eight-lane output frame register with valid/ready handshake
// Purpose: holds one assembled frame and owns the load/consume rules for out_valid.
// Ports:
//   clock, reset_n   system clock, synchronous active-low reset
//   load, load_data  capture a new frame (only asserted by the parent when free is high)
//   out_ready        downstream consumes the held frame
//   lanes, out_valid held frame and its valid flag
//   free             register can take a load this cycle (empty, or being consumed)
module fmt_demux_outreg
  import formatter_demux_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   load,
  input  frame_t load_data,
  input  logic   out_ready,
  output frame_t lanes,
  output logic   out_valid,
  output logic   free
);

  assign free = ~out_valid | out_ready;

  // A load wins over a consume in the same cycle, keeping out_valid high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lanes     <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      lanes     <= load_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/formatter_demux.sv
// rtl/formatter_demux.sv - 1-to-8 deserializer assembling 21-bit words into eight-lane frames
// Purpose: collects eight consecutive words (first one flagged by din_first) and hands the
//          frame downstream; flags framing errors with a one-cycle err pulse.
// Ports:
//   clock, reset_n                  system clock, synchronous active-low reset
//   din, din_valid, din_first       input word, its valid, slot-0 marker
//   din_ready                       word accepted this cycle (decoded from state only)
//   out1..out8, out_valid, out_ready frame lanes (outN = slot N-1) and handshake
//   err                             one-cycle framing error pulse
//   err_cnt                         saturating error count (only with FMT_DEMUX_ERRCNT_EN)
module formatter_demux
  import formatter_demux_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_first,
  output logic             din_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FMT_DEMUX_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             err
);

  state_t              state, state_n;
  logic [SLOT_W-1:0]   slot, slot_n;
  frame_t              buffer, load_data, lanes;
  logic                accept, free, load, load_din, err_n, wr_en;
  logic [SLOT_W-1:0]   wr_idx;

  assign din_ready = (state != ST_FULL);
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    err_n    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = slot;
    load     = 1'b0;
    load_din = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (din_first) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            slot_n  = SLOT_W'(1);
            state_n = ST_COLLECT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          if (din_first) begin
            // Resync: restart the frame with this word, even on slot 7.
            err_n  = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
            slot_n = SLOT_W'(1);
          end else if (slot == SLOT_W'(NSLOT - 1)) begin
            slot_n = '0;
            if (free) begin
              // Last word bypasses the buffer straight into the output register.
              load     = 1'b1;
              load_din = 1'b1;
              state_n  = ST_IDLE;
            end else begin
              wr_en   = 1'b1;
              state_n = ST_FULL;
            end
          end else begin
            wr_en  = 1'b1;
            slot_n = slot + SLOT_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (free) begin
          load    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    load_data = buffer;
    if (load_din) load_data[NSLOT-1] = din;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      slot   <= '0;
      err    <= 1'b0;
      buffer <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      err   <= err_n;
      if (wr_en) buffer[wr_idx] <= din;
    end
  end

`ifdef FMT_DEMUX_ERRCNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (err_n && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

  fmt_demux_outreg u_outreg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .lanes     (lanes),
    .out_valid (out_valid),
    .free      (free)
  );

  assign out1 = lanes[0];
  assign out2 = lanes[1];
  assign out3 = lanes[2];
  assign out4 = lanes[3];
  assign out5 = lanes[4];
  assign out6 = lanes[5];
  assign out7 = lanes[6];
  assign out8 = lanes[7];

endmodule

// File: tb/tb_formatter_demux.sv
// tb/tb_formatter_demux.sv - self-checking bench for formatter_demux with a frame scoreboard
module tb_formatter_demux;
  import formatter_demux_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_first = 1'b0;
  logic        out_ready = 1'b0;
  logic        din_ready, out_valid, err;
  logic [20:0] out1, out2, out3, out4, out5, out6, out7, out8;
`ifdef FMT_DEMUX_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clock = ~clock;

  formatter_demux dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .din       (din),
    .din_valid (din_valid),
    .din_first (din_first),
    .din_ready (din_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out8      (out8),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FMT_DEMUX_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .err       (err)
  );

  int     n_cmp = 0;
  int     n_fail = 0;
  int     err_seen = 0;
  bit     done_rand = 1'b0;
  frame_t exp_q[$];
  frame_t got, exp_f;

  assign got = {out8, out7, out6, out5, out4, out3, out2, out1};

  // Scoreboard: every consume handshake pops the oldest expected frame.
  always @(negedge clock) begin
    if (reset_n) begin
      if (err) err_seen++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got %h, required no frame", got);
        end else begin
          exp_f = exp_q.pop_front();
          if (got !== exp_f) begin
            n_fail++;
            $display("FAIL frame_lanes: got %h, required %h", got, exp_f);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [20:0] w, input bit first);
    int t = 0;
    bit acc = 1'b0;
    din       = w;
    din_valid = 1'b1;
    din_first = first;
    while (!acc && t < 200) begin
      acc = din_ready;
      tick();
      t++;
    end
    din_valid = 1'b0;
    din_first = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got din_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 8; i++) send_word(f[i], i == 0);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    din_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || err !== 1'b0 || din_ready !== 1'b1 || got !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b err=%b ready=%b lanes=%h, required 0 0 1 0",
               out_valid, err, din_ready, got);
    end
`ifdef FMT_DEMUX_ERRCNT_EN
    n_cmp++;
    if (err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
    end
`endif
    reset_n = 1'b1;
    tick();
    err_seen = 0;
  endtask

  task automatic test_single_frame();
    frame_t f;
    int e0 = err_seen;
    for (int i = 0; i < 8; i++) f[i] = 21'(i + 1);
    out_ready = 1'b1;
    exp_q.push_back(f);
    for (int i = 0; i < 8; i++) begin
      send_word(f[i], i == 0);
      if (i == 6) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early_valid: got %b, required 0", out_valid);
        end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1 || got !== f) begin
      n_fail++;
      $display("FAIL single_latency: got valid=%b lanes=%h, required 1 %h", out_valid, got, f);
    end
    repeat (2) tick();
    n_cmp++;
    if (err_seen !== e0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got errs=%0d valid=%b, required %0d 0", err_seen, out_valid, e0);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    for (int i = 0; i < 8; i++) begin
      f1[i] = 21'(i + 1);
      f2[i] = 21'(i + 9);
    end
    out_ready = 1'b0;
    exp_q.push_back(f1);
    exp_q.push_back(f2);
    send_frame(f1);
    send_frame(f2);
    n_cmp++;
    if (din_ready !== 1'b0 || out_valid !== 1'b1 || got !== f1) begin
      n_fail++;
      $display("FAIL b2b_stall: got ready=%b valid=%b lanes=%h, required 0 1 %h",
               din_ready, out_valid, got, f1);
    end
    repeat (2) tick();
    n_cmp++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: got din_ready=%b, required 0", din_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (din_ready !== 1'b1 || out_valid !== 1'b1 || got !== f2) begin
      n_fail++;
      $display("FAIL b2b_release: got ready=%b valid=%b lanes=%h, required 1 1 %h",
               din_ready, out_valid, got, f2);
    end
    out_ready = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_resync();
    frame_t f, g;
    int e0 = err_seen;
    out_ready = 1'b1;
    f[0] = 21'h1FFFFF;
    for (int i = 1; i < 8; i++) f[i] = 21'(32'h200 + i - 1);
    exp_q.push_back(f);
    for (int i = 0; i < 4; i++) send_word(21'(32'h100 + i), i == 0);
    send_word(f[0], 1'b1);
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_err_pulse: got %b, required 1", err);
    end
    tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_err_width: got %b, required 0", err);
    end
    for (int i = 1; i < 8; i++) send_word(f[i], 1'b0);
    for (int i = 0; i < 8; i++) g[i] = 21'(32'h300 + i);
    exp_q.push_back(g);
    for (int i = 0; i < 7; i++) send_word(21'(32'h400 + i), i == 0);
    send_frame(g);
    repeat (3) tick();
    n_cmp++;
    if (err_seen !== e0 + 2 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_count: got errs=%0d valid=%b, required %0d 0", err_seen, out_valid, e0 + 2);
    end
  endtask

  task automatic test_idle_errors();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_word(21'(32'h50 + i), 1'b0);
    repeat (2) tick();
    n_cmp++;
    if (err_seen !== 3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_errors: got errs=%0d valid=%b, required 3 0", err_seen, out_valid);
    end
`ifdef FMT_DEMUX_ERRCNT_EN
    n_cmp++;
    if (err_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL idle_err_cnt: got %0d, required 3", err_cnt);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    frame_t lost, clean;
    int e0 = err_seen;
    for (int i = 0; i < 8; i++) begin
      lost[i]  = 21'(32'h700 + i);
      clean[i] = 21'(32'h800 + i);
    end
    out_ready = 1'b0;
    send_frame(lost);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_held: got valid=%b, required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) send_word(21'(32'h900 + i), i == 0);
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || got !== '0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_clear: got valid=%b lanes=%h ready=%b, required 0 0 1",
               out_valid, got, din_ready);
    end
    reset_n   = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(clean);
    send_frame(clean);
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0 || err_seen !== e0) begin
      n_fail++;
      $display("FAIL midreset_clean: got pending=%0d errs=%0d, required 0 %0d", exp_q.size(), err_seen, e0);
    end
  endtask

  task automatic test_random();
    int e0 = err_seen;
    int t = 0;
    done_rand = 1'b0;
    fork
      begin
        while (!done_rand) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        frame_t f;
        for (int n = 0; n < 1000; n++) begin
          for (int i = 0; i < 8; i++) f[i] = 21'($urandom());
          exp_q.push_back(f);
          for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_word(f[i], i == 0);
          end
        end
        done_rand = 1'b1;
      end
    join
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || err_seen !== e0) begin
      n_fail++;
      $display("FAIL random_drain: got pending=%0d errs=%0d, required 0 %0d", exp_q.size(), err_seen, e0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_resync();
    test_reset();
    test_idle_errors();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/formatter_demux.md
# formatter_demux

Synchronous 1-to-8 deserializer: the receive-side counterpart of the 8-to-1 formatter multiplexer. Accepts a stream of 21-bit words, one per cycle, and assembles each run of eight consecutive words into a parallel frame of eight 21-bit lanes. Hands each frame downstream with a valid/ready handshake. Sits at the input of the fitter datapath, where serialized formatter output is re-expanded into per-layer words.

## Interface
- WIDTH, 21, word width (fixed at 21 in this design)
- NSLOT, 8, words per frame (fixed at 8; slot counter is 3 bits)

- CLOCK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  synchronous reset, active low
- DIN  in  21  input word
- DIN_VALID  in  1  DIN holds a word this cycle
- DIN_FIRST  in  1  qualifies DIN as slot 0 of a frame; meaningful only with DIN_VALID
- DIN_READY  out  1  block accepts a word this cycle
- OUT1..OUT8  out  21 each  frame lanes; OUTn = slot n-1
- OUT_VALID  out  1  frame on OUT1..OUT8 is valid
- OUT_READY  in  1  downstream consumes the frame
- ERR  out  1  one-cycle pulse on a framing error
- ERR_CNT  out  16  saturating error count (only with FMT_DEMUX_ERRCNT_EN)

## Operation
- Accept = DIN_VALID & DIN_READY. Consume = OUT_VALID & OUT_READY.
- State machine, 2-bit state, 3-bit slot counter SLOT:
  - IDLE: waiting for slot 0. Accept with DIN_FIRST -> store to buffer slot 0, SLOT=1, go COLLECT. Accept without DIN_FIRST -> word dropped, ERR pulse, stay IDLE.
  - COLLECT: accept without DIN_FIRST -> store to buffer[SLOT], SLOT+1. Accept with DIN_FIRST (resync) -> ERR pulse, partial frame discarded, word stored to slot 0, SLOT=1. On accept of slot 7: if output register empty or Consume this cycle, the full frame (slots 0–6 plus DIN) loads into OUT1..OUT8 at that edge, go IDLE; otherwise store slot 7, go FULL.
  - FULL: DIN_READY=0. When output register is empty or Consume occurs, buffer loads into OUT1..OUT8, go IDLE.
- DIN_READY = (state != FULL). Combinational from state only, never from OUT_READY.
- OUT_VALID set on frame load; cleared on Consume with no simultaneous load. A load in the same cycle as Consume keeps OUT_VALID high. OUT1..OUT8 change only on load.
- SLOT wraps 7 -> 0 only via frame completion; slot count 8 is never stored.
- DIN_FIRST on a slot-7 accept counts as resync, not completion.
- Reset: state=IDLE, SLOT=0, OUT_VALID=0, OUT1..OUT8=0, ERR=0, ERR_CNT=0, buffer=0. Reset mid-frame or with OUT_VALID high discards all data, and a held frame is lost.

## Timing
- All outputs are registered except DIN_READY, which is decoded from the state register.
- Latency: OUT_VALID rises one cycle after the slot-7 accept edge when the output register is free.
- Throughput: one frame per 8 cycles with OUT_READY held high; DIN_READY never drops in that case.
- Stall: with OUT_READY low and a frame already held, the next frame completes into FULL. DIN_READY falls the cycle after the slot-7 accept and rises the cycle after the Consume edge.
- ERR is high for exactly one cycle, the cycle after the offending accept edge.

## Configuration
- FMT_DEMUX_ERRCNT_EN defined: ERR_CNT present. It increments on each ERR event and saturates at 16'hFFFF; reset clears it.
- Not defined: ERR_CNT port and counter are absent; ERR pulse is unchanged.

## Structure
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_FULL=2'd2), WIDTH=21, NSLOT=8, SLOT_W=3.
- One sub-module: fmt_demux_outreg, the 8-lane output register with OUT_VALID/OUT_READY logic, so the load/consume rules are in one place.
- The main module holds the FSM, slot counter, collection buffer and error logic.

## Test plan
- Reset, then DIN_FIRST with words 21'h000001..21'h000008 on consecutive cycles, OUT_READY=1 -> OUT1..OUT8 = 1..8, OUT_VALID high one cycle after the 8th accept, ERR never asserts.
- Two back-to-back frames (1..8, 9..16) with OUT_READY=0 -> first frame held, DIN_READY=0 after the 16th word. Then OUT_READY=1 for one cycle -> OUT shows 9..16, DIN_READY returns 1, OUT_VALID stays high.
- DIN_FIRST at slot 4 with word 21'h1FFFFF, then seven more words -> one ERR pulse, OUT1=21'h1FFFFF, partial frame discarded.
- Three valid words without DIN_FIRST while in IDLE -> three ERR pulses, no frame produced, and ERR_CNT=3 when FMT_DEMUX_ERRCNT_EN is defined.
- RESET_N low for one cycle after 5 accepted words, then a full clean frame -> OUT_VALID=0 during reset, and the clean frame is output intact.
- Random DIN_VALID/OUT_READY backpressure over 1000 frames against a scoreboard -> every frame arrives in order with lanes matching slot order.
